// File: rtl/sdram_romrq_rnd_pkg.sv
// Shared constants for the SDRAM ROM request front end: legal client widths,
// LFSR seed and feedback tap mask.
package sdram_romrq_rnd_pkg;

    localparam int          SDRAM_AW  = 22;
    localparam logic [15:0] LFSR_SEED = 16'h0001;
    // Taps 16,14,13,11 map to state bits 15,13,12,10.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic bit dw_legal(input int dw);
        return (dw == 8) || (dw == 16) || (dw == 32);
    endfunction

    // Number of client address LSBs that select a unit inside a 32-bit word.
    function automatic int dw_lsbs(input int dw);
        return (dw == 8) ? 2 : ((dw == 16) ? 1 : 0);
    endfunction

endpackage

// File: rtl/sdram_lfsr16.sv
// 16-bit Fibonacci LFSR used by clients for timing jitter; advances on adv.
module sdram_lfsr16
    import sdram_romrq_rnd_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        adv,
    output logic [15:0] lfsr
);

    logic [15:0] lfsr_q;
    logic [15:0] lfsr_d;
    logic        fb;

    assign fb = ^(lfsr_q & LFSR_TAPS);

    always_comb begin
        lfsr_d = lfsr_q;
        if (adv) begin
            lfsr_d = {lfsr_q[14:0], fb};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            lfsr_q <= LFSR_SEED;
        end else begin
            lfsr_q <= lfsr_d;
        end
    end

    assign lfsr = lfsr_q;

endmodule

// File: rtl/sdram_romrq_rnd.sv
// SDRAM ROM client front end: address translation, two-entry MRU read cache
// of 32-bit words, and an LFSR for jitter.
module sdram_romrq_rnd
    import sdram_romrq_rnd_pkg::*;
#(
    parameter int AW     = 22,
    parameter int DW     = 16,
    parameter int REPACK = 0
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                clr,
    input  logic [SDRAM_AW-1:0] offset,
    input  logic [AW-1:0]       addr,
    input  logic                addr_ok,
    input  logic [31:0]         din,
    input  logic                din_ok,
    input  logic                we,
    output logic                req,
    output logic                data_ok,
    output logic [SDRAM_AW-1:0] sdram_addr,
    output logic [DW-1:0]       dout,
    input  logic                adv,
    output logic [15:0]         lfsr
);

    localparam int LSBS = dw_legal(DW) ? dw_lsbs(DW) : 0;

    logic [AW-1:0]       addr_req;
    logic [SDRAM_AW-1:0] word_addr;

    generate
        if (LSBS == 0) begin : g_align_none
            assign addr_req = addr;
        end else begin : g_align
            assign addr_req = {addr[AW-1:LSBS], {LSBS{1'b0}}};
        end

        // Byte clients count in bytes, SDRAM counts 16-bit words.
        if (DW == 8) begin : g_waddr8
            assign word_addr = SDRAM_AW'(addr_req >> 1);
        end else begin : g_waddr
            assign word_addr = SDRAM_AW'(addr_req);
        end
    endgenerate

    assign sdram_addr = offset + word_addr;

    logic [AW-1:0] tag_q  [0:1];
    logic [31:0]   data_q [0:1];
    logic [1:0]    valid_q;

    // Entry 0 is always the most recent fill; the older line shifts to entry 1.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_q   <= 2'b00;
            tag_q[0]  <= '0;
            tag_q[1]  <= '0;
            data_q[0] <= '0;
            data_q[1] <= '0;
        end else if (clr) begin
            valid_q <= 2'b00;
        end else if (we && din_ok) begin
            tag_q[1]  <= tag_q[0];
            data_q[1] <= data_q[0];
            tag_q[0]  <= addr_req;
            data_q[0] <= din;
            valid_q   <= {valid_q[0], 1'b1};
        end
    end

    logic        hit0;
    logic        hit1;
    logic        hit;
    logic [31:0] hit_data;
    logic [DW-1:0] word_c;
    logic        ok_c;

    assign hit0     = valid_q[0] && (tag_q[0] == addr_req);
    assign hit1     = valid_q[1] && (tag_q[1] == addr_req);
    assign hit      = hit0 || hit1;
    assign hit_data = hit0 ? data_q[0] : data_q[1];

    generate
        if (DW == 16) begin : g_sel16
            assign word_c = addr[0] ? hit_data[31:16] : hit_data[15:0];
        end else if (DW == 8) begin : g_sel8
            assign word_c = hit_data[{addr[1:0], 3'b000} +: 8];
        end else begin : g_sel32
            assign word_c = DW'(hit_data);
        end
    endgenerate

    assign req  = rst_n && addr_ok && !hit && !we;
    assign ok_c = addr_ok && hit;

    generate
        if (REPACK != 0) begin : g_repack
            logic          data_ok_q;
            logic [DW-1:0] dout_q;

            always_ff @(posedge clk) begin
                if (!rst_n) begin
                    data_ok_q <= 1'b0;
                    dout_q    <= '0;
                end else begin
                    data_ok_q <= ok_c;
                    dout_q    <= word_c;
                end
            end

            assign data_ok = data_ok_q;
            assign dout    = dout_q;
        end else begin : g_direct
            assign data_ok = ok_c;
            assign dout    = word_c;
        end
    endgenerate

    sdram_lfsr16 u_lfsr (
        .clk   (clk),
        .rst_n (rst_n),
        .adv   (adv),
        .lfsr  (lfsr)
    );

endmodule

// File: tb/tb_sdram_romrq_rnd.sv
// Bench for sdram_romrq_rnd: three parameterisations share one stimulus stream
// and are checked against an MRU-list reference model, plus directed vectors.
module tb_sdram_romrq_rnd;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n, clr, we, din_ok, addr_ok, adv;
    logic [21:0] offset, addr;
    logic [31:0] din;

    logic [2:0]  req_a, ok_a;
    logic [21:0] saddr_a [3];
    logic [15:0] lfsr_a  [3];
    logic [15:0] dout16, dout16r;
    logic [7:0]  dout8;

    sdram_romrq_rnd #(.AW(22), .DW(16), .REPACK(0)) u16 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .offset(offset), .addr(addr),
        .addr_ok(addr_ok), .din(din), .din_ok(din_ok), .we(we), .req(req_a[0]),
        .data_ok(ok_a[0]), .sdram_addr(saddr_a[0]), .dout(dout16), .adv(adv),
        .lfsr(lfsr_a[0]));

    sdram_romrq_rnd #(.AW(22), .DW(16), .REPACK(1)) u16r (
        .clk(clk), .rst_n(rst_n), .clr(clr), .offset(offset), .addr(addr),
        .addr_ok(addr_ok), .din(din), .din_ok(din_ok), .we(we), .req(req_a[1]),
        .data_ok(ok_a[1]), .sdram_addr(saddr_a[1]), .dout(dout16r), .adv(adv),
        .lfsr(lfsr_a[1]));

    sdram_romrq_rnd #(.AW(22), .DW(8), .REPACK(0)) u8 (
        .clk(clk), .rst_n(rst_n), .clr(clr), .offset(offset), .addr(addr),
        .addr_ok(addr_ok), .din(din), .din_ok(din_ok), .we(we), .req(req_a[2]),
        .data_ok(ok_a[2]), .sdram_addr(saddr_a[2]), .dout(dout8), .adv(adv),
        .lfsr(lfsr_a[2]));

    int pass_cnt = 0;
    int total_cnt = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act !== exp) begin
            $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, exp, $time);
        end else begin
            pass_cnt++;
        end
    endtask

    // Reference model: per instance, a most-recent-first list of at most two lines.
    typedef struct packed {
        logic [21:0] tag;
        logic [31:0] data;
    } ent_t;

    ent_t        mq [3][$];
    int          mdw  [3] = '{16, 16, 8};
    int          mrep [3] = '{0, 1, 0};
    logic        mreg_ok   [3];
    logic [31:0] mreg_dout [3];
    logic        cur_ok    [3];
    logic [31:0] cur_word  [3];
    logic [15:0] mlfsr;

    function automatic logic [21:0] align(input logic [21:0] a, input int dw);
        if (dw == 8)  return {a[21:2], 2'b00};
        if (dw == 16) return {a[21:1], 1'b0};
        return a;
    endfunction

    function automatic logic [32:0] lookup(input int k);
        logic [21:0] areq;
        logic [31:0] d;
        logic        h;
        areq = align(addr, mdw[k]);
        h = 1'b0;
        d = 32'h0;
        foreach (mq[k][i]) begin
            if (!h && mq[k][i].tag == areq) begin
                h = 1'b1;
                d = mq[k][i].data;
            end
        end
        if (mdw[k] == 16)     d = addr[0] ? {16'h0, d[31:16]} : {16'h0, d[15:0]};
        else if (mdw[k] == 8) d = (d >> (8 * addr[1:0])) & 32'hFF;
        return {h, d};
    endfunction

    function automatic logic [31:0] act_dout(input int k);
        if (k == 0) return {16'h0, dout16};
        if (k == 1) return {16'h0, dout16r};
        return {24'h0, dout8};
    endfunction

    task automatic to_negedge();
        logic [32:0] r;
        logic        eok;
        logic [31:0] ed;
        logic [21:0] esa;
        @(negedge clk);
        for (int k = 0; k < 3; k++) begin
            r = lookup(k);
            cur_ok[k]   = addr_ok && r[32];
            cur_word[k] = r[31:0];
            chk($sformatf("req[%0d]", k), {31'h0, req_a[k]},
                {31'h0, rst_n && addr_ok && !r[32] && !we});
            eok = mrep[k] != 0 ? mreg_ok[k]   : cur_ok[k];
            ed  = mrep[k] != 0 ? mreg_dout[k] : cur_word[k];
            chk($sformatf("data_ok[%0d]", k), {31'h0, ok_a[k]}, {31'h0, eok});
            if (eok) chk($sformatf("dout[%0d]", k), act_dout(k), ed);
            esa = align(addr, mdw[k]);
            if (mdw[k] == 8) esa = esa >> 1;
            esa = offset + esa;
            chk($sformatf("sdram_addr[%0d]", k), {10'h0, saddr_a[k]}, {10'h0, esa});
            chk($sformatf("lfsr[%0d]", k), {16'h0, lfsr_a[k]}, {16'h0, mlfsr});
        end
    endtask

    task automatic to_posedge();
        ent_t e;
        for (int k = 0; k < 3; k++) begin
            if (!rst_n) begin
                mq[k].delete();
                mreg_ok[k]   = 1'b0;
                mreg_dout[k] = 32'h0;
            end else begin
                mreg_ok[k]   = cur_ok[k];
                mreg_dout[k] = cur_word[k];
                if (clr) begin
                    mq[k].delete();
                end else if (we && din_ok) begin
                    e.tag  = align(addr, mdw[k]);
                    e.data = din;
                    mq[k].push_front(e);
                    if (mq[k].size() > 2) void'(mq[k].pop_back());
                end
            end
        end
        if (!rst_n)   mlfsr = 16'h0001;
        else if (adv) mlfsr = {mlfsr[14:0], mlfsr[15] ^ mlfsr[13] ^ mlfsr[12] ^ mlfsr[10]};
        @(posedge clk);
        #1;
    endtask

    task automatic set_in(input logic r, input logic c, input logic [21:0] off,
                          input logic [21:0] a, input logic aok, input logic w,
                          input logic dok, input logic [31:0] d);
        rst_n = r; clr = c; offset = off; addr = a; addr_ok = aok;
        we = w; din_ok = dok; din = d; adv = 1'b0;
    endtask

    typedef struct {
        logic        rst_n, clr;
        logic [21:0] offset, addr;
        logic        addr_ok, we, din_ok;
        logic [31:0] din;
        logic        exp_req, exp_ok;
        logic [15:0] exp_dout;
        logic [21:0] exp_saddr;
    } vec_t;

    vec_t tbl [22];

    function automatic vec_t mk(input logic r, input logic c, input logic [21:0] off,
                                input logic [21:0] a, input logic aok, input logic w,
                                input logic dok, input logic [31:0] d, input logic erq,
                                input logic eok, input logic [15:0] ed, input logic [21:0] es);
        vec_t v;
        v.rst_n = r; v.clr = c; v.offset = off; v.addr = a; v.addr_ok = aok;
        v.we = w; v.din_ok = dok; v.din = d; v.exp_req = erq; v.exp_ok = eok;
        v.exp_dout = ed; v.exp_saddr = es;
        return v;
    endfunction

    logic [15:0] lfsr_exp [12];

    initial begin
        // Expectations for the DW=16, REPACK=0 instance.
        tbl[0]  = mk(1,0,22'h0,     22'h10,1,0,0,32'h0,        1,0,16'h0,   22'h010);
        tbl[1]  = mk(1,0,22'h100,   22'h21,1,0,0,32'h0,        1,0,16'h0,   22'h120);
        tbl[2]  = mk(1,0,22'h100,   22'h21,1,1,0,32'h0,        0,0,16'h0,   22'h120);
        tbl[3]  = mk(1,0,22'h100,   22'h21,1,1,1,32'hBEEF1234, 0,0,16'h0,   22'h120);
        tbl[4]  = mk(1,0,22'h100,   22'h21,1,0,0,32'h0,        0,1,16'hBEEF,22'h120);
        tbl[5]  = mk(1,0,22'h100,   22'h20,1,0,0,32'h0,        0,1,16'h1234,22'h120);
        tbl[6]  = mk(1,0,22'h100,   22'h40,1,1,1,32'hCAFE5678, 0,0,16'h0,   22'h140);
        tbl[7]  = mk(1,0,22'h100,   22'h21,1,0,0,32'h0,        0,1,16'hBEEF,22'h120);
        tbl[8]  = mk(1,0,22'h100,   22'h60,1,1,1,32'h9999AAAA, 0,0,16'h0,   22'h160);
        tbl[9]  = mk(1,0,22'h100,   22'h20,1,0,0,32'h0,        1,0,16'h0,   22'h120);
        tbl[10] = mk(1,0,22'h100,   22'h41,1,0,0,32'h0,        0,1,16'hCAFE,22'h140);
        tbl[11] = mk(1,1,22'h100,   22'h40,1,0,0,32'h0,        0,1,16'h5678,22'h140);
        tbl[12] = mk(1,0,22'h100,   22'h40,1,0,0,32'h0,        1,0,16'h0,   22'h140);
        tbl[13] = mk(1,0,22'h100,   22'h60,1,0,0,32'h0,        1,0,16'h0,   22'h160);
        tbl[14] = mk(1,1,22'h100,   22'h20,1,1,1,32'h11112222, 0,0,16'h0,   22'h120);
        tbl[15] = mk(1,0,22'h100,   22'h20,1,0,0,32'h0,        1,0,16'h0,   22'h120);
        tbl[16] = mk(1,0,22'h100,   22'h20,1,1,1,32'h33334444, 0,0,16'h0,   22'h120);
        tbl[17] = mk(1,0,22'h100,   22'h20,1,0,0,32'h0,        0,1,16'h4444,22'h120);
        tbl[18] = mk(0,0,22'h100,   22'h20,1,0,0,32'h0,        0,1,16'h4444,22'h120);
        tbl[19] = mk(1,0,22'h100,   22'h20,1,0,0,32'h0,        1,0,16'h0,   22'h120);
        tbl[20] = mk(1,0,22'h3FFFFF,22'h21,1,0,0,32'h0,        1,0,16'h0,   22'h01F);
        tbl[21] = mk(1,0,22'h0,     22'h20,0,0,0,32'h0,        0,0,16'h0,   22'h020);
        for (int i = 0; i < 11; i++) lfsr_exp[i] = 16'h0001 << i;
        lfsr_exp[11] = 16'h0801;

        set_in(0, 0, 22'h0, 22'h10, 1, 0, 0, 32'h0);
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 3; k++) begin
            mreg_ok[k] = 1'b0;
            mreg_dout[k] = 32'h0;
            cur_ok[k] = 1'b0;
            cur_word[k] = 32'h0;
        end
        mlfsr = 16'h0001;

        // Reset exit and LFSR sequence.
        rst_n = 1'b1;
        adv = 1'b1;
        for (int i = 0; i < 12; i++) begin
            to_negedge();
            chk($sformatf("lfsr_seq%0d", i), {16'h0, lfsr_a[0]}, {16'h0, lfsr_exp[i]});
            if (i == 0) begin
                chk("rst_req", {31'h0, req_a[0]}, 32'h1);
                chk("rst_ok", {31'h0, ok_a[0]}, 32'h0);
                chk("rst_saddr", {10'h0, saddr_a[0]}, 32'h10);
                chk("rst_ok_rep", {31'h0, ok_a[1]}, 32'h0);
                chk("rst_dout_rep", {16'h0, dout16r}, 32'h0);
            end
            $display("lfsr step %0d lfsr=%h", i, lfsr_a[0]);
            to_posedge();
        end

        // Directed vector table.
        for (int i = 0; i < 22; i++) begin
            set_in(tbl[i].rst_n, tbl[i].clr, tbl[i].offset, tbl[i].addr,
                   tbl[i].addr_ok, tbl[i].we, tbl[i].din_ok, tbl[i].din);
            to_negedge();
            chk($sformatf("vec%0d_req", i), {31'h0, req_a[0]}, {31'h0, tbl[i].exp_req});
            chk($sformatf("vec%0d_ok", i), {31'h0, ok_a[0]}, {31'h0, tbl[i].exp_ok});
            chk($sformatf("vec%0d_saddr", i), {10'h0, saddr_a[0]}, {10'h0, tbl[i].exp_saddr});
            if (tbl[i].exp_ok)
                chk($sformatf("vec%0d_dout", i), {16'h0, dout16}, {16'h0, tbl[i].exp_dout});
            $display("vec %0d addr=%h req=%b ok=%b dout=%h saddr=%h",
                     i, addr, req_a[0], ok_a[0], dout16, saddr_a[0]);
            to_posedge();
        end

        // DW=8 byte selection.
        set_in(0, 0, 22'h0, 22'h13, 1, 0, 0, 32'h0);
        to_negedge(); to_posedge();
        set_in(1, 0, 22'h0, 22'h13, 1, 0, 0, 32'h0);
        to_negedge();
        chk("b8_saddr", {10'h0, saddr_a[2]}, 32'h8);
        chk("b8_req", {31'h0, req_a[2]}, 32'h1);
        to_posedge();
        set_in(1, 0, 22'h0, 22'h13, 1, 1, 1, 32'h44332211);
        to_negedge(); to_posedge();
        set_in(1, 0, 22'h0, 22'h13, 1, 0, 0, 32'h0);
        to_negedge();
        chk("b8_ok", {31'h0, ok_a[2]}, 32'h1);
        chk("b8_dout13", {24'h0, dout8}, 32'h44);
        to_posedge();
        addr = 22'h10;
        to_negedge();
        chk("b8_dout10", {24'h0, dout8}, 32'h11);
        $display("byte seq dout=%h", dout8);
        to_posedge();

        // REPACK=1 latency and req suppression while we is high.
        set_in(1, 1, 22'h100, 22'h21, 1, 1, 0, 32'h0);
        to_negedge(); to_posedge();
        clr = 1'b0;
        to_negedge();
        chk("rp_req_we", {31'h0, req_a[1]}, 32'h0);
        chk("rp_saddr", {10'h0, saddr_a[1]}, 32'h120);
        to_posedge();
        set_in(1, 0, 22'h100, 22'h21, 1, 1, 1, 32'hBEEF1234);
        to_negedge(); to_posedge();
        set_in(1, 0, 22'h100, 22'h21, 1, 0, 0, 32'h0);
        to_negedge();
        chk("rp_ok_early", {31'h0, ok_a[1]}, 32'h0);
        chk("rp_ok_direct", {31'h0, ok_a[0]}, 32'h1);
        to_posedge();
        to_negedge();
        chk("rp_ok_late", {31'h0, ok_a[1]}, 32'h1);
        chk("rp_dout_late", {16'h0, dout16r}, 32'hBEEF);
        $display("repack seq ok=%b dout=%h", ok_a[1], dout16r);
        to_posedge();

        // Randomised traffic against the model.
        for (int n = 0; n < 500; n++) begin
            rst_n   = ($urandom_range(0, 99) != 0);
            clr     = ($urandom_range(0, 29) == 0);
            if ($urandom_range(0, 19) == 0) offset = 22'($urandom);
            addr    = 22'($urandom_range(0, 127));
            addr_ok = ($urandom_range(0, 3) != 0);
            we      = ($urandom_range(0, 2) == 0);
            din_ok  = ($urandom_range(0, 1) == 1);
            din     = $urandom;
            adv     = ($urandom_range(0, 1) == 1);
            to_negedge();
            to_posedge();
        end

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
